// File: rtl/tl_monitor.sv
// Traffic-light monitor: rebuilds the controller state S0..S7 from the two
// light codes, times each state's dwell and flags illegal or conflicting lights.
module tl_monitor #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         La,
    input  logic [1:0]         Lb,
    input  logic               clr,
    output logic               locked,
    output logic [2:0]         state_est,
    output logic [DWELL_W-1:0] dwell,
    output logic [7:0]         cycle_cnt,
    output logic               err_seq,
    output logic               err_conflict,
    output logic               err_flag
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        TRACK    = 1'b1
    } fsm_e;

    localparam logic [3:0]         LOCK_CODE = 4'b1000;
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    // {La,Lb} the controller drives while sitting in state s
    function automatic logic [3:0] code_of(input logic [2:0] s);
        logic [3:0] c;
        case (s)
            3'd0:    c = 4'b1000;
            3'd1:    c = 4'b0100;
            3'd2:    c = 4'b1100;
            3'd3:    c = 4'b0100;
            3'd4:    c = 4'b0010;
            3'd5:    c = 4'b0001;
            3'd6:    c = 4'b0011;
            default: c = 4'b0001;
        endcase
        return c;
    endfunction

    fsm_e               fsm_q, fsm_d;
    logic [2:0]         state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         cycle_q, cycle_d;
    logic               seq_q, seq_d;
    logic               conf_q, conf_d;
    logic               flag_q, flag_d;

    logic [3:0] sample;
    logic [2:0] succ;
    logic       conflict;
    logic       wrap;

    assign sample   = {La, Lb};
    assign succ     = state_q + 3'd1;
    assign conflict = (La != 2'b00) && (Lb != 2'b00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= UNLOCKED;
            state_q <= '0;
            dwell_q <= '0;
            cycle_q <= '0;
            seq_q   <= 1'b0;
            conf_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            dwell_q <= dwell_d;
            cycle_q <= cycle_d;
            seq_q   <= seq_d;
            conf_q  <= conf_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        dwell_d = dwell_q;
        seq_d   = 1'b0;
        conf_d  = conflict;
        wrap    = 1'b0;
        unique case (fsm_q)
            UNLOCKED: begin
                if (sample == LOCK_CODE) begin
                    fsm_d   = TRACK;
                    state_d = 3'd0;
                    dwell_d = DWELL_ONE;
                end
            end
            TRACK: begin
                if (!conflict && sample == code_of(state_q)) begin
                    if (dwell_q != DWELL_MAX) dwell_d = dwell_q + DWELL_ONE;
                end else if (!conflict && sample == code_of(succ)) begin
                    state_d = succ;
                    dwell_d = DWELL_ONE;
                    wrap    = (state_q == 3'd7);
                end else begin
                    seq_d   = 1'b1;
                    fsm_d   = UNLOCKED;
                    state_d = 3'd0;
                    dwell_d = '0;
                end
            end
            default: fsm_d = UNLOCKED;
        endcase
        // a rotation completing alongside clr still counts
        cycle_d = (clr ? 8'd0 : cycle_q) + {7'd0, wrap};
        flag_d  = (flag_q & ~clr) | seq_d | conf_d;
    end

    always_comb begin
        locked       = (fsm_q == TRACK);
        state_est    = state_q;
        dwell        = dwell_q;
        cycle_cnt    = cycle_q;
        err_seq      = seq_q;
        err_conflict = conf_q;
        err_flag     = flag_q;
    end

endmodule

// File: tb/tb_tl_monitor.sv
// Bench for tl_monitor: directed light sequences checked against a
// per-cycle reference model and a set of literal expectations.
module tb_tl_monitor;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] La = 2'b00;
    logic [1:0] Lb = 2'b00;
    logic       clr = 1'b0;
    logic       locked;
    logic [2:0] state_est;
    logic [7:0] dwell;
    logic [7:0] cycle_cnt;
    logic       err_seq;
    logic       err_conflict;
    logic       err_flag;

    tl_monitor #(.DWELL_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .La           (La),
        .Lb           (Lb),
        .clr          (clr),
        .locked       (locked),
        .state_est    (state_est),
        .dwell        (dwell),
        .cycle_cnt    (cycle_cnt),
        .err_seq      (err_seq),
        .err_conflict (err_conflict),
        .err_flag     (err_flag)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int code_a [8] = '{2, 1, 3, 1, 0, 0, 0, 0};
    int code_b [8] = '{0, 0, 0, 0, 2, 1, 3, 1};

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: plain integers, state numbers and a code table
    bit m_lk, m_es, m_ec, m_ef;
    int m_st, m_dw, m_cyc;
    bit nx_lk, nx_es, nx_ec, nx_ef;
    int nx_st, nx_dw, nx_cyc;

    always_comb begin
        nx_lk  = m_lk;
        nx_st  = m_st;
        nx_dw  = m_dw;
        nx_es  = 1'b0;
        nx_ec  = (La != 2'd0) && (Lb != 2'd0);
        nx_cyc = clr ? 0 : m_cyc;
        if (!m_lk) begin
            if (La == 2'd2 && Lb == 2'd0) begin
                nx_lk = 1'b1;
                nx_st = 0;
                nx_dw = 1;
            end
        end else if (!nx_ec && La == code_a[m_st] && Lb == code_b[m_st]) begin
            nx_dw = (m_dw < 255) ? m_dw + 1 : 255;
        end else if (!nx_ec && La == code_a[(m_st + 1) % 8]
                     && Lb == code_b[(m_st + 1) % 8]) begin
            nx_st = (m_st + 1) % 8;
            nx_dw = 1;
            if (nx_st == 0) nx_cyc = (nx_cyc + 1) % 256;
        end else begin
            nx_es = 1'b1;
            nx_lk = 1'b0;
            nx_st = 0;
            nx_dw = 0;
        end
        nx_ef = (m_ef && !clr) || nx_es || nx_ec;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_lk <= 1'b0; m_st <= 0; m_dw <= 0; m_cyc <= 0;
            m_es <= 1'b0; m_ec <= 1'b0; m_ef <= 1'b0;
        end else begin
            m_lk <= nx_lk; m_st <= nx_st; m_dw <= nx_dw; m_cyc <= nx_cyc;
            m_es <= nx_es; m_ec <= nx_ec; m_ef <= nx_ef;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_locked", locked, m_lk);
            check("m_state", state_est, m_st);
            check("m_dwell", dwell, m_dw);
            check("m_cycle", cycle_cnt, m_cyc);
            check("m_err_seq", err_seq, m_es);
            check("m_err_conf", err_conflict, m_ec);
            check("m_err_flag", err_flag, m_ef);
        end
    end

    task automatic drive(input int a, input int b, input logic c);
        @(negedge clk);
        La  = 2'(a);
        Lb  = 2'(b);
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_state"}, state_est, 0);
        check({tag, "_dwell"}, dwell, 0);
        check({tag, "_cycle"}, cycle_cnt, 0);
        check({tag, "_seq"}, err_seq, 0);
        check({tag, "_conf"}, err_conflict, 0);
        check({tag, "_flag"}, err_flag, 0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1 check_reset_vals("rst");
        @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // lock-on after all-red
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1'b0);
            check("pre_lock", locked, 0);
        end
        drive(2, 0, 1'b0);
        check("lock", locked, 1);
        check("lock_state", state_est, 0);
        check("lock_dwell", dwell, 1);
        check("lock_flag", err_flag, 0);

        // full rotation, three cycles per state
        for (int k = 2; k <= 3; k++) begin
            drive(2, 0, 1'b0);
            check("s0_dwell", dwell, k);
        end
        for (int s = 1; s < 8; s++) begin
            for (int k = 1; k <= 3; k++) begin
                drive(code_a[s], code_b[s], 1'b0);
                check("rot_state", state_est, s);
                check("rot_dwell", dwell, k);
            end
        end
        drive(2, 0, 1'b0);
        check("wrap_state", state_est, 0);
        check("wrap_dwell", dwell, 1);
        check("wrap_cycle", cycle_cnt, 1);

        // skipped yellow
        drive(3, 0, 1'b0);
        check("skip_seq", err_seq, 1);
        check("skip_locked", locked, 0);
        check("skip_flag", err_flag, 1);
        check("skip_state", state_est, 0);
        drive(0, 0, 1'b0);
        check("skip_pulse", err_seq, 0);
        check("skip_sticky", err_flag, 1);
        drive(0, 0, 1'b1);
        check("clr_flag", err_flag, 0);
        check("clr_cycle", cycle_cnt, 0);

        // conflict while tracking, then while unlocked
        drive(2, 0, 1'b0);
        drive(2, 2, 1'b0);
        check("conf_conf", err_conflict, 1);
        check("conf_seq", err_seq, 1);
        check("conf_locked", locked, 0);
        drive(1, 1, 1'b0);
        check("uconf_conf", err_conflict, 1);
        check("uconf_seq", err_seq, 0);
        drive(0, 0, 1'b1);

        // dwell saturation, then clr racing an illegal sample
        for (int i = 0; i < 300; i++) drive(2, 0, 1'b0);
        check("sat_dwell", dwell, 255);
        check("sat_locked", locked, 1);
        drive(0, 0, 1'b1);
        check("race_seq", err_seq, 1);
        check("race_flag", err_flag, 1);

        // clr coinciding with an S7->S0 wrap
        drive(2, 0, 1'b0);
        for (int s = 1; s < 8; s++) drive(code_a[s], code_b[s], 1'b0);
        drive(2, 0, 1'b0);
        check("cyc_one", cycle_cnt, 1);
        for (int s = 1; s < 8; s++) drive(code_a[s], code_b[s], 1'b0);
        drive(2, 0, 1'b1);
        check("cyc_clr_wrap", cycle_cnt, 1);
        check("cyc_clr_flag", err_flag, 0);

        // asynchronous reset in S5
        for (int s = 1; s <= 5; s++) drive(code_a[s], code_b[s], 1'b0);
        check("pre_rst_state", state_est, 5);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("arst");
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 0, 1'b0);
        check("relock_wait", locked, 0);
        drive(2, 0, 1'b0);
        check("relock", locked, 1);
        check("relock_dwell", dwell, 1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tl_monitor.md
TL_MONITOR -- requirements
Module: tl_monitor

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 8, giving the dwell counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port La, input, 2 bits: the street-A light code.
REQ-005 The block SHALL have port Lb, input, 2 bits: the street-B light code.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear of err_flag and cycle_cnt.
REQ-007 The block SHALL have port locked, output, 1 bit: the reconstructed state is valid.
REQ-008 The block SHALL have port state_est, output, 3 bits: the reconstructed controller state S0..S7.
REQ-009 The block SHALL have port dwell, output, DWELL_W bits: the cycles spent in the current state.
REQ-010 The block SHALL have port cycle_cnt, output, 8 bits: the completed full A/B rotations.
REQ-011 The block SHALL have port err_seq, output, 1 bit: one-cycle pulse on an illegal light sequence.
REQ-012 The block SHALL have port err_conflict, output, 1 bit: one-cycle pulse when both streets are non-red.
REQ-013 The block SHALL have port err_flag, output, 1 bit: sticky OR of err_seq and err_conflict.

Function
REQ-014 Light codes SHALL be decoded as 00 red, 01 yellow, 10 green, 11 left-turn.
REQ-015 The expected {La,Lb} for each state SHALL be: S0 10/00, S1 01/00, S2 11/00, S3 01/00, S4 00/10, S5 00/01, S6 00/11, S7 00/01.
REQ-016 The legal order SHALL be S0>S1>S2>S3>S4>S5>S6>S7>S0; the S1/S3 and S5/S7 code ambiguity SHALL be resolved by the tracked predecessor.
REQ-017 {La,Lb} SHALL be sampled every rising edge, and all outputs SHALL be registered, reflecting the sample taken at that edge (1-cycle latency).
REQ-018 The control FSM SHALL have two states, UNLOCKED and TRACK.
REQ-019 In UNLOCKED, a sample of 10/00 SHALL move the FSM to TRACK with state_est=0 and dwell=1; any other sample SHALL leave it in UNLOCKED with no error.
REQ-020 In TRACK, a sample equal to the current state's code SHALL hold state_est and increment dwell, saturating at 2^DWELL_W-1.
REQ-021 In TRACK, a sample equal to the successor state's code SHALL advance state_est by 1 modulo 8 and set dwell=1.
REQ-022 In TRACK, any other sample (including 00/00 all-red) SHALL pulse err_seq for one cycle, move the FSM to UNLOCKED, and set state_est=0 and dwell=0.
REQ-023 In either FSM state, La!=00 and Lb!=00 in the same sample SHALL pulse err_conflict; in TRACK this sample SHALL also pulse err_seq and apply the REQ-022 handling.
REQ-024 An advance from S7 to S0 SHALL increment cycle_cnt, wrapping 255 to 0.
REQ-025 locked SHALL be 1 exactly when the FSM is in TRACK.
REQ-026 err_flag SHALL set on any err_seq or err_conflict pulse and SHALL clear only on clr=1; an error in the same cycle as clr SHALL win, leaving err_flag=1.
REQ-027 clr SHALL zero cycle_cnt; an S7>S0 advance in the same cycle as clr SHALL leave cycle_cnt=1.
REQ-028 clr SHALL NOT affect the FSM, state_est, or dwell.

Reset
REQ-029 On reset_n=0 the block SHALL immediately, without waiting for a clock edge, enter UNLOCKED with locked=0, state_est=0, dwell=0, cycle_cnt=0, err_seq=0, err_conflict=0, and err_flag=0.
REQ-030 A reset asserted mid-tracking SHALL discard all history, and relock SHALL require a fresh 10/00 sample after reset_n returns to 1.

Verification
REQ-031 The bench SHALL drive 3 cycles of 00/00 and then 10/00, and check that locked rises on the 10/00 edge with state_est=0, dwell=1, and no error.
REQ-032 The bench SHALL drive a full legal rotation with 3 cycles per state, and check that state_est steps 0..7, dwell cycles 1,2,3, S1 and S3 are distinguished correctly, and cycle_cnt=1 after returning to S0.
REQ-033 The bench SHALL drive 10/00, then 11/00 (skipping yellow), and check for an err_seq pulse, locked=0, err_flag=1, and state_est=0.
REQ-034 The bench SHALL drive 10/10 while tracking, and check that err_conflict=1, err_seq=1, and locked=0 on the same edge.
REQ-035 The bench SHALL hold S0 for 300 cycles with DWELL_W=8, and check that dwell saturates at 255; it SHALL then assert clr in the same cycle as an illegal sample, and check that err_flag stays 1.
REQ-036 The bench SHALL assert reset_n=0 asynchronously between edges while in S5, and check that all outputs go to their reset values before the next clk edge.
